// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and width constants.
// Imported by the fetch stage and the decoder so both agree on pc_control encodings.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // next-PC select driven by the decoder; 3'b101..3'b111 are reserved and behave as PC_SEQ
  localparam logic [2:0] PC_SEQ = 3'b000;
  localparam logic [2:0] PC_BEQ = 3'b001;
  localparam logic [2:0] PC_BNE = 3'b010;
  localparam logic [2:0] PC_J   = 3'b011;
  localparam logic [2:0] PC_JR  = 3'b100;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  // Sign-extended word offset converted to a byte offset.
  function automatic logic [ADDR_W-1:0] branch_byte_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage: sequential, conditional branches,
// J-type absolute jumps and register-indirect jumps. All adds wrap modulo 2^32.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  pc_control,
  input  logic        alu_zero,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_addr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_aligned;
  logic        jr_low_unused;

  assign pc4           = pc + 32'd4;
  assign branch_target = pc4 + branch_byte_offset(branch_imm);
  assign jump_target   = {pc4[31:28], jump_addr, 2'b00};
  // A misaligned register target is forced onto a word boundary rather than trapping.
  assign jr_aligned    = {jr_target[31:2], 2'b00};
  assign jr_low_unused = ^jr_target[1:0];

  always_comb begin
    next_pc = pc4;
    case (pc_control)
      PC_SEQ: next_pc = pc4;
      PC_BEQ: next_pc = alu_zero ? branch_target : pc4;
      PC_BNE: next_pc = alu_zero ? pc4 : branch_target;
      PC_J:   next_pc = jump_target;
      PC_JR:  next_pc = jr_aligned;
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over req/ack and
// hands it to the decoder over valid/ready; the next PC is taken on the consume cycle.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc,
  input  logic [2:0]         pc_control,
  input  logic               alu_zero,
  input  logic [15:0]        branch_imm,
  input  logic [25:0]        jump_addr,
  input  logic [31:0]        jr_target
);

  fetch_state_t       state_reg;
  logic [31:0]        pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               instr_valid_reg;
  logic               imem_req_reg;
  logic [31:0]        pc_next;

  next_pc_calc u_next_pc_calc (
    .pc         (pc_reg),
    .pc_control (pc_control),
    .alu_zero   (alu_zero),
    .branch_imm (branch_imm),
    .jump_addr  (jump_addr),
    .jr_target  (jr_target),
    .next_pc    (pc_next)
  );

  // req stays low for the first cycle after reset so an ack still in flight is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      imem_req_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_valid_reg && instr_ready) begin
            pc_reg          <= {pc_next[31:2], 2'b00};
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= FETCH;
          end
        end
        default: begin
          state_reg    <= FETCH;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of next-PC vectors plus hand-written sequences for
// throughput, wait states, back-pressure and mid-fetch reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [2:0]  pc_control = 3'b000;
  logic        alu_zero = 1'b0;
  logic [15:0] branch_imm = '0;
  logic [25:0] jump_addr = '0;
  logic [31:0] jr_target = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int word_cnt = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_control(pc_control), .alu_zero(alu_zero), .branch_imm(branch_imm),
    .jump_addr(jump_addr), .jr_target(jr_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic [2:0]  ctl;
    logic        zero;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] jr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Wait for a request, check address, insert wait states, ack, then check the presented word.
  task automatic fetch(input logic [31:0] exp_addr, input int delay, input int max_wait);
    int w;
    logic [31:0] data;
    w = 0;
    data = exp_addr ^ 32'hA5C3_0000 ^ 32'(word_cnt);
    word_cnt++;
    while (!imem_req && w < 20) begin
      step;
      w++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_latency_ok", {31'd0, (w <= max_wait)}, 32'd1);
    chk("imem_addr", imem_addr, exp_addr);
    for (int d = 0; d < delay; d++) begin
      imem_ack = 1'b0;
      step;
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, exp_addr);
      chk("no_spurious_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step;
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("instr_word", instr, data);
    chk("req_dropped", {31'd0, imem_req}, 32'd0);
    chk("pc_of_instr", pc, exp_addr);
    $display("fetch addr=0x%08h waits=%0d instr=0x%08h", exp_addr, delay, instr);
  endtask

  // Hold back-pressure (with stray acks), then consume with the given next-PC controls.
  task automatic consume(input logic [2:0] ctl, input logic zero, input logic [15:0] imm,
                         input logic [25:0] jaddr, input logic [31:0] jr, input int hold);
    logic [31:0] i0, p0;
    i0 = instr;
    p0 = pc;
    for (int h = 0; h < hold; h++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = 32'hDEAD_0000 | 32'(h);
      pc_control  = PC_J;
      jump_addr   = 26'h3FF_FFFF;
      step;
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, i0);
      chk("bp_pc", pc, p0);
      chk("bp_no_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    pc_control  = ctl;
    alu_zero    = zero;
    branch_imm  = imm;
    jump_addr   = jaddr;
    jr_target   = jr;
    step;
    instr_ready = 1'b0;
    pc_control  = PC_JR;
    jr_target   = 32'hCCCC_CCCC;
    chk("valid_cleared", {31'd0, instr_valid}, 32'd0);
    chk("req_after_consume", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"beq_taken",     32'h0000_0040, PC_BEQ, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h0000_003C};
    vecs[1]  = '{"beq_not_taken", 32'h0000_0040, PC_BEQ, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h0000_0044};
    vecs[2]  = '{"bne_not_taken", 32'h0000_0040, PC_BNE, 1'b1, 16'hFFFE, 26'h0, 32'h0, 32'h0000_0044};
    vecs[3]  = '{"bne_taken",     32'h0000_0040, PC_BNE, 1'b0, 16'hFFFE, 26'h0, 32'h0, 32'h0000_003C};
    vecs[4]  = '{"jump",          32'h9000_0010, PC_J,   1'b0, 16'h0,    26'h0000_100, 32'h0, 32'h9000_0400};
    vecs[5]  = '{"jr_misaligned", 32'h0000_0080, PC_JR,  1'b0, 16'h0,    26'h0, 32'h1234_5677, 32'h1234_5674};
    vecs[6]  = '{"seq_wrap",      32'hFFFF_FFFC, PC_SEQ, 1'b0, 16'h0,    26'h0, 32'h0, 32'h0000_0000};
    vecs[7]  = '{"reserved_101",  32'h0000_0100, 3'b101, 1'b1, 16'h0010, 26'h3, 32'h4444_4444, 32'h0000_0104};
    vecs[8]  = '{"reserved_111",  32'h0000_0200, 3'b111, 1'b0, 16'h0010, 26'h3, 32'h4444_4444, 32'h0000_0204};
    vecs[9]  = '{"beq_forward",   32'h0000_1000, PC_BEQ, 1'b1, 16'h0010, 26'h0, 32'h0, 32'h0000_1044};
    vecs[10] = '{"jump_pc4_nib",  32'h0FFF_FFFC, PC_J,   1'b1, 16'h0,    26'h3FF_FFFF, 32'h0, 32'h1FFF_FFFC};
    vecs[11] = '{"bne_min_imm",   32'h0002_0000, PC_BNE, 1'b0, 16'h8000, 26'h0, 32'h0, 32'h0000_0004};
    vecs[12] = '{"jr_low01",      32'h0000_0300, PC_JR,  1'b1, 16'h0,    26'h0, 32'h8000_0021, 32'h8000_0020};

    // Reset state
    repeat (3) step;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    rst_n = 1'b1;

    // Back-to-back fetches, zero wait states, immediate ready
    fetch(32'h0, 0, 1);
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0);
    fetch(32'h4, 0, 0);
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0);
    fetch(32'h8, 0, 0);
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0);
    fetch(32'hC, 0, 0);
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0);

    // Three wait states at 0x10, then five cycles of back-pressure
    fetch(32'h10, 3, 0);
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 5);
    fetch(32'h14, 0, 0);

    // Next-PC vectors: steer pc to start_pc with JR, then apply the vector
    foreach (vecs[i]) begin
      consume(PC_JR, 1'b0, 16'h0, 26'h0, vecs[i].start_pc, 0);
      fetch(vecs[i].start_pc, 0, 0);
      consume(vecs[i].ctl, vecs[i].zero, vecs[i].imm, vecs[i].jaddr, vecs[i].jr, 0);
      fetch(vecs[i].exp_next, 1, 0);
      $display("vector %s: pc 0x%08h -> 0x%08h", vecs[i].name, vecs[i].start_pc, vecs[i].exp_next);
    end

    // Reset mid-FETCH with a stale ack pending
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0);
    chk("midrst_in_fetch", {31'd0, imem_req}, 32'd1);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_instr", instr, 32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'd0);
    chk("stale_not_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_not_instr", instr, 32'd0);
    imem_ack = 1'b0;
    fetch(32'h0, 1, 0);
    consume(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 0);
    fetch(32'h4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
